// File: rtl/axis_zmod_acq_ctrl_if.sv
// AXI4-Stream bundle shared by the ADC input and packet output
// of the Zmod acquisition controller.
interface axis_zmod_acq_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_zmod_acq_ctrl.sv
// Triggered acquisition controller: arms, waits a holdoff, detects a
// level/external trigger and forwards one fixed-length AXIS packet.
module axis_zmod_acq_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cfg_trg_src,
    input  logic                  cfg_edge,
    input  logic [15:0]           cfg_level,
    input  logic [CNTR_WIDTH-1:0] cfg_holdoff,
    input  logic [CNTR_WIDTH-1:0] cfg_length,
    input  logic                  trg_ext,
    axis_zmod_acq_ctrl_if.slave   s_axis,
    axis_zmod_acq_ctrl_if.master  m_axis,
    output logic [2:0]            sts_state,
    output logic [CNTR_WIDTH-1:0] sts_count,
    output logic                  sts_overflow
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

    state_e                      state_q, state_d;
    logic [CNTR_WIDTH-1:0]       hold_q, hold_d;
    logic [CNTR_WIDTH-1:0]       len_q, len_d;
    logic [CNTR_WIDTH-1:0]       count_q, count_d;
    logic signed [15:0]          level_q, level_d;
    logic signed [15:0]          prev_a_q, prev_a_d;
    logic                        edge_q, edge_d;
    logic                        src_q, src_d;
    logic                        ext_q, ext_d;
    logic                        ovf_q, ovf_d;
    logic                        stopping_q, stopping_d;
    logic                        vld_q, vld_d;
    logic                        last_q, last_d;
    logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;

    logic signed [15:0]    cur_a;
    logic                  out_free;
    logic                  arm_go;
    logic                  lvl_rise, lvl_fall;
    logic                  ext_rise, ext_fall;
    logic                  trig;
    logic [CNTR_WIDTH-1:0] cnt_inc;

    assign cur_a    = s_axis.tdata[15:0];
    assign out_free = !vld_q || m_axis.tready;
    assign cnt_inc  = count_q + ONE;

    assign lvl_rise = (prev_a_q < level_q) && (cur_a >= level_q);
    assign lvl_fall = (prev_a_q > level_q) && (cur_a <= level_q);
    assign ext_rise = trg_ext && !ext_q;
    assign ext_fall = !trg_ext && ext_q;

    always_comb begin
        trig = 1'b0;
        if (src_q) begin
            trig = edge_q ? ext_fall : ext_rise;
        end else begin
            trig = edge_q ? lvl_fall : lvl_rise;
        end
    end

    // DONE only re-arms once the final beat has left the output register
    assign arm_go = start && !stop &&
                    ((state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_free));

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        len_d      = len_q;
        count_d    = count_q;
        level_d    = level_q;
        edge_d     = edge_q;
        src_d      = src_q;
        ovf_d      = ovf_q;
        stopping_d = stopping_q;
        vld_d      = vld_q;
        last_d     = last_q;
        data_d     = data_q;
        prev_a_d   = s_axis.tvalid ? cur_a : prev_a_q;
        ext_d      = trg_ext;

        if (vld_q && m_axis.tready) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_go) begin
                    state_d = S_ARM;
                    hold_d  = cfg_holdoff;
                    len_d   = (cfg_length == '0) ? ONE : cfg_length;
                    level_d = cfg_level;
                    edge_d  = cfg_edge;
                    src_d   = cfg_trg_src;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end

            S_ARM: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (hold_q == '0) begin
                    state_d = S_WAIT;
                end else if (s_axis.tvalid) begin
                    hold_d = hold_q - ONE;
                end
            end

            S_WAIT: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (s_axis.tvalid && trig) begin
                    vld_d   = 1'b1;
                    data_d  = s_axis.tdata;
                    last_d  = (len_q == ONE);
                    count_d = ONE;
                    state_d = (len_q == ONE) ? S_DONE : S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (stopping_q) begin
                    if (out_free) begin
                        state_d    = S_IDLE;
                        stopping_d = 1'b0;
                    end
                end else if (stop) begin
                    // a stalled beat becomes the truncated packet's last
                    if (vld_q && !m_axis.tready) begin
                        stopping_d = 1'b1;
                        last_d     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (s_axis.tvalid) begin
                    if (out_free) begin
                        vld_d   = 1'b1;
                        data_d  = s_axis.tdata;
                        count_d = cnt_inc;
                        last_d  = (cnt_inc == len_q);
                        if (cnt_inc == len_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            level_q    <= '0;
            prev_a_q   <= '0;
            edge_q     <= 1'b0;
            src_q      <= 1'b0;
            ext_q      <= 1'b0;
            ovf_q      <= 1'b0;
            stopping_q <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            count_q    <= count_d;
            level_q    <= level_d;
            prev_a_q   <= prev_a_d;
            edge_q     <= edge_d;
            src_q      <= src_d;
            ext_q      <= ext_d;
            ovf_q      <= ovf_d;
            stopping_q <= stopping_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign s_axis.tready = 1'b1;
    assign m_axis.tvalid = vld_q;
    assign m_axis.tdata  = data_q;
    assign m_axis.tlast  = last_q;
    assign sts_state     = state_q;
    assign sts_count     = count_q;
    assign sts_overflow  = ovf_q;

endmodule

// File: tb/tb_axis_zmod_acq_ctrl.sv
// Directed bench for the Zmod acquisition controller: trigger modes,
// holdoff, back-pressure, stop, zero length and mid-packet reset.
module tb_axis_zmod_acq_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_trg_src = 1'b0;
    logic        cfg_edge = 1'b0;
    logic [15:0] cfg_level = '0;
    logic [15:0] cfg_holdoff = '0;
    logic [15:0] cfg_length = '0;
    logic        trg_ext = 1'b0;
    logic [2:0]  sts_state;
    logic [15:0] sts_count;
    logic        sts_overflow;

    axis_zmod_acq_ctrl_if #(.DATA_WIDTH(32)) s_if ();
    axis_zmod_acq_ctrl_if #(.DATA_WIDTH(32)) m_if ();

    axis_zmod_acq_ctrl #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH      (16)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .stop        (stop),
        .cfg_trg_src (cfg_trg_src),
        .cfg_edge    (cfg_edge),
        .cfg_level   (cfg_level),
        .cfg_holdoff (cfg_holdoff),
        .cfg_length  (cfg_length),
        .trg_ext     (trg_ext),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .sts_state   (sts_state),
        .sts_count   (sts_count),
        .sts_overflow(sts_overflow)
    );

    always #5 aclk = ~aclk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [32:0] beats[$];
    int          exp_q[$];

    always @(posedge aclk) begin
        if (aresetn && m_if.tvalid && m_if.tready) begin
            beats.push_back({m_if.tlast, m_if.tdata});
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic feed(input int a, input int b);
        s_if.tvalid = 1'b1;
        s_if.tdata  = {16'(b), 16'(a)};
        tick();
    endtask

    task automatic idle_in(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic cfg_start(input logic src, input logic edg, input int lvl,
                             input int hold, input int len);
        cfg_trg_src = src;
        cfg_edge    = edg;
        cfg_level   = 16'(lvl);
        cfg_holdoff = 16'(hold);
        cfg_length  = 16'(len);
        s_if.tvalid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_pkt(input string tag);
        logic [32:0] b;
        check({tag, "_len"}, 64'(beats.size()), 64'(exp_q.size()));
        for (int i = 0; i < beats.size() && i < exp_q.size(); i++) begin
            b = beats[i];
            check(tag, {b[32], b[15:0]},
                  {(i == exp_q.size() - 1), 16'(exp_q[i])});
        end
    endtask

    initial begin
        int          arm_n;
        logic [32:0] b;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) tick();
        check("rst_state", sts_state, 3'd0);
        check("rst_tvalid", m_if.tvalid, 1'b0);
        check("rst_tlast", m_if.tlast, 1'b0);
        check("rst_tdata", m_if.tdata, 32'h0);
        check("rst_count", sts_count, 16'd0);
        check("rst_ovf", sts_overflow, 1'b0);
        aresetn = 1'b1;
        tick();

        // level 0 rising, holdoff 4, length 8, ramp -10..20
        beats.delete();
        cfg_start(1'b0, 1'b0, 0, 4, 8);
        arm_n = 0;
        if (sts_state == 3'd1) arm_n++;
        for (int v = -10; v <= 20; v++) begin
            feed(v, 16'h1000 + v + 10);
            if (sts_state == 3'd1) arm_n++;
        end
        idle_in(2);
        check("t1_arm_cycles", 64'(arm_n), 64'd5);
        check("t1_len", 64'(beats.size()), 64'd8);
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            b = beats[i];
            check("t1_beat", b, {(i == 7), 16'(16'h100A + i), 16'(i)});
        end
        check("t1_ovf", sts_overflow, 1'b0);
        check("t1_state", sts_state, 3'd4);
        check("t1_count", sts_count, 16'd8);

        // falling edge at 100, length 2
        cfg_start(1'b0, 1'b1, 100, 0, 2);
        idle_in(1);
        check("t2_wait", sts_state, 3'd2);
        beats.delete();
        feed(120, 0);
        feed(110, 0);
        feed(100, 0);
        feed(90, 0);
        idle_in(2);
        exp_q = '{100, 90};
        check_pkt("t2_pkt");

        // 3-cycle stall inside a 16-beat packet
        cfg_start(1'b0, 1'b0, 0, 0, 16);
        idle_in(1);
        beats.delete();
        for (int v = -1; v <= 25; v++) begin
            m_if.tready = (v >= 5 && v <= 7) ? 1'b0 : 1'b1;
            feed(v, 0);
            if (v >= 5 && v <= 7) begin
                check("t3_stall_vld", m_if.tvalid, 1'b1);
                check("t3_stall_dat", m_if.tdata[15:0], 16'd4);
            end
        end
        m_if.tready = 1'b1;
        idle_in(2);
        exp_q.delete();
        for (int v = 0; v <= 18; v++) begin
            if (v < 5 || v > 7) exp_q.push_back(v);
        end
        check_pkt("t3_pkt");
        check("t3_ovf", sts_overflow, 1'b1);
        check("t3_count", sts_count, 16'd16);
        check("t3_state", sts_state, 3'd4);

        // external rising edge: ARM pulse ignored, WAIT pulse triggers
        cfg_start(1'b1, 1'b0, 0, 3, 3);
        beats.delete();
        for (int i = 0; i < 10; i++) begin
            trg_ext = (i == 0 || i == 5);
            feed(200 + i, 0);
            if (i == 3) check("t4_wait", sts_state, 3'd2);
        end
        trg_ext = 1'b0;
        idle_in(2);
        exp_q = '{205, 206, 207};
        check_pkt("t4_pkt");

        // stop with a stalled beat pending
        cfg_start(1'b0, 1'b0, 0, 0, 10);
        idle_in(1);
        beats.delete();
        feed(-5, 0);
        feed(5, 0);
        m_if.tready = 1'b0;
        s_if.tvalid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_hold_vld", m_if.tvalid, 1'b1);
        check("t5_hold_last", m_if.tlast, 1'b1);
        check("t5_hold_dat", m_if.tdata[15:0], 16'd5);
        check("t5_hold_st", sts_state, 3'd3);
        feed(7, 0);
        check("t5_hold2_st", sts_state, 3'd3);
        check("t5_hold2_dat", m_if.tdata[15:0], 16'd5);
        m_if.tready = 1'b1;
        idle_in(1);
        check("t5_idle", sts_state, 3'd0);
        check("t5_vld", m_if.tvalid, 1'b0);
        exp_q = '{5};
        check_pkt("t5_pkt");

        // start and stop together in WAIT
        cfg_start(1'b0, 1'b0, 0, 0, 10);
        idle_in(1);
        check("t5_wait", sts_state, 3'd2);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t5_ss_idle", sts_state, 3'd0);

        // length 0 behaves as a single beat
        cfg_start(1'b0, 1'b0, 0, 0, 0);
        idle_in(1);
        beats.delete();
        feed(-3, 0);
        feed(3, 0);
        check("t6_vld", m_if.tvalid, 1'b1);
        check("t6_last", m_if.tlast, 1'b1);
        check("t6_dat", m_if.tdata[15:0], 16'd3);
        check("t6_state", sts_state, 3'd4);
        check("t6_count", sts_count, 16'd1);
        idle_in(2);
        check("t6_len", 64'(beats.size()), 64'd1);

        // reset in the middle of a stalled capture
        cfg_start(1'b0, 1'b0, 0, 0, 8);
        idle_in(1);
        feed(-2, 0);
        m_if.tready = 1'b0;
        feed(2, 0);
        feed(3, 0);
        check("t7_ovf_pre", sts_overflow, 1'b1);
        check("t7_st_pre", sts_state, 3'd3);
        aresetn = 1'b0;
        s_if.tvalid = 1'b0;
        tick();
        check("t7_vld", m_if.tvalid, 1'b0);
        check("t7_last", m_if.tlast, 1'b0);
        check("t7_dat", m_if.tdata, 32'h0);
        check("t7_state", sts_state, 3'd0);
        check("t7_count", sts_count, 16'd0);
        check("t7_ovf", sts_overflow, 1'b0);
        aresetn = 1'b1;
        m_if.tready = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_zmod_acq_ctrl.md
# axis_zmod_acq_ctrl

Triggered acquisition controller for the Zmod ADC sample stream. It sits downstream of the ADC capture core and upstream of the DMA/FIFO. It consumes the free-running 32-bit packed two-channel stream and, on software command, arms, waits a programmable holdoff, detects a level-crossing or external trigger, then forwards exactly a programmed number of samples as one AXI4-Stream packet terminated by `tlast`. Status outputs report state, progress and a sticky overflow flag for the PS register bank.

## Interface
- `AXIS_TDATA_WIDTH`, 32: stream width; channel A in `[15:0]`, channel B in `[31:16]`, both sign-extended two's complement.
- `CNTR_WIDTH`, 16: width of holdoff/length counters.
- `aclk`  in  1  sole clock; all logic on rising edge.
- `aresetn`  in  1  synchronous active-low reset.
- `start`  in  1  one-cycle arm request.
- `stop`  in  1  one-cycle abort request.
- `cfg_trg_src`  in  1  0 = level crossing on channel A, 1 = external.
- `cfg_edge`  in  1  0 = rising, 1 = falling.
- `cfg_level`  in  16  signed threshold.
- `cfg_holdoff`  in  CNTR_WIDTH  valid samples to skip after arming.
- `cfg_length`  in  CNTR_WIDTH  beats per packet; 0 is treated as 1.
- `trg_ext`  in  1  synchronous external trigger level.
- `s_axis_tvalid`  in  1; `s_axis_tdata`  in  AXIS_TDATA_WIDTH  ADC stream (no tready; the source cannot stall).
- `m_axis_tready`  in  1; `m_axis_tvalid`  out  1; `m_axis_tdata`  out  AXIS_TDATA_WIDTH; `m_axis_tlast`  out  1.
- `sts_state`  out  3  encoded FSM state.
- `sts_count`  out  CNTR_WIDTH  beats accepted into output register this packet.
- `sts_overflow`  out  1  sticky; cleared by `start`.

## Operation
- States: IDLE=0, ARM=1, WAIT=2, CAPTURE=3, DONE=4.
- `start` in IDLE or DONE: latch all `cfg_*`, load holdoff counter, clear `sts_count` and `sts_overflow`, go to ARM. `start` is ignored in other states.
- ARM: counter decrements on each `s_axis_tvalid`. At counter==0, go to WAIT next cycle. ARM lasts ≥ 1 cycle; with `cfg_holdoff`=0 it lasts exactly 1 cycle.
- Previous-sample register `prev_a` loads `s_axis_tdata[15:0]` on every valid cycle in all states.
- Level trigger, evaluated in WAIT on a valid cycle only:
  - rising: `prev_a < level && cur_a >= level`;
  - falling: `prev_a > level && cur_a <= level`;
  - all comparisons signed 16-bit.
- External trigger: `trg_ext` registered once; the edge per `cfg_edge` between the registered and current value counts as a trigger on a valid cycle in WAIT. Edges outside WAIT are discarded.
- On trigger: the triggering sample is the first beat. Load it into the output register, set `sts_count`=1, go to CAPTURE (or DONE if length==1).
- CAPTURE: each valid input sample loads the output register if the register is empty or being accepted this cycle (`!m_axis_tvalid || m_axis_tready`), and increments `sts_count`. Otherwise the sample is dropped, not counted, and `sts_overflow` is set. A packet always has exactly `cfg_length` beats; overflow marks a discontinuity.
- `m_axis_tlast`=1 on the beat whose load makes `sts_count`==length. FSM goes to DONE on that load.
- DONE: waits for final beat acceptance; then holds until `start`.
- `stop`: from ARM/WAIT go to IDLE. From CAPTURE, a pending beat is held, its `tlast` forced to 1, no further loads occur, and the FSM goes to IDLE after acceptance (immediately if none pending). Ignored in IDLE/DONE. `stop` wins over a same-cycle `start`.
- AXIS rule: once asserted, `m_axis_tvalid`/`tdata`/`tlast` stay stable until `m_axis_tready`.

## Timing
- Reset (`aresetn`=0 at edge): state IDLE, all outputs 0, counters and `prev_a` 0. Reset mid-packet discards the pending beat immediately; this is the only permitted AXIS violation.
- Latency: sample on `s_axis_tdata` at cycle N appears on `m_axis_tdata` at N+1 (single register stage).
- `start` at cycle N: `sts_state`=ARM visible at N+1.
- Trigger arriving in the same cycle ARM expires is not recognized; detection begins the cycle WAIT is visible.
- Throughput: 1 beat/cycle with `m_axis_tready` held high; zero drops.
- `sts_count` wraps never: it saturates at `cfg_length`.

## Test plan
- Holdoff 4, length 8, level 0 rising, ramp −10..+20 on A, tready=1 -> ARM 5 cycles; first beat A=0 (crossing at −1→0); 8 contiguous beats; tlast on A=7; overflow=0; state DONE.
- Falling edge, level 100, input 120,110,100,90 -> trigger on 100; samples at 110 are not triggers.
- tready low for 3 cycles mid-capture, length 16 -> exactly 16 beats, 3 samples dropped, `sts_overflow`=1, tvalid/tdata stable while stalled.
- cfg_trg_src=1, pulse `trg_ext` during ARM then again in WAIT -> first ignored; capture starts on the sample coincident with the second edge.
- `stop` during CAPTURE with beat pending and tready=0 -> beat held with tlast=1; IDLE one cycle after acceptance. `start`+`stop` same cycle in WAIT -> IDLE.
- length 0 -> single beat with tlast=1. Reset asserted mid-CAPTURE -> all outputs 0 next cycle.
